// File: rtl/lc4_div_sched_if.sv
`default_nettype none
// ==========================================================================
// lc4_div_sched_if : request/grant, flush and response bundle for the divider
// Revision         : 1.0
// ==========================================================================
interface lc4_div_sched_if #(
  parameter int WIDTH = 16
);
  logic             i_flush;
  logic             i_a_req;
  logic             i_a_is_mod;
  logic [WIDTH-1:0] i_a_dividend;
  logic [WIDTH-1:0] i_a_divisor;
  logic             o_a_gnt;
  logic             i_b_req;
  logic             i_b_is_mod;
  logic [WIDTH-1:0] i_b_dividend;
  logic [WIDTH-1:0] i_b_divisor;
  logic             o_b_gnt;
  logic             o_rsp_valid;
  logic             o_rsp_id;
  logic [WIDTH-1:0] o_rsp_result;
  logic             i_rsp_ready;
  logic             o_busy;

  modport slave (
    input  i_flush, i_a_req, i_a_is_mod, i_a_dividend, i_a_divisor,
    input  i_b_req, i_b_is_mod, i_b_dividend, i_b_divisor, i_rsp_ready,
    output o_a_gnt, o_b_gnt, o_rsp_valid, o_rsp_id, o_rsp_result, o_busy
  );

  modport master (
    output i_flush, i_a_req, i_a_is_mod, i_a_dividend, i_a_divisor,
    output i_b_req, i_b_is_mod, i_b_dividend, i_b_divisor, i_rsp_ready,
    input  o_a_gnt, o_b_gnt, o_rsp_valid, o_rsp_id, o_rsp_result, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/lc4_div_sched.sv
`default_nettype none
// ==========================================================================
// lc4_div_sched : shared restoring divider (DIV/MOD) arbitrated between pipes
// Revision      : 1.0
// ==========================================================================
module lc4_div_sched #(
  parameter int WIDTH      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input wire              clk,
  input wire              rst,
  lc4_div_sched_if.slave  bus
);
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_mod_q, is_mod_d;
  logic             id_q, id_d;
  logic             last_b_q, last_b_d;

  logic             win_a, win_b, gnt_a, gnt_b, accept;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;
  logic             sel_mod;
  logic [WIDTH:0]   shift_r;
  logic [WIDTH-1:0] diff;
  logic             step_ge;

  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (bus.i_a_req && bus.i_b_req) begin
      // last_b_q resets high so pipe A takes the first tie
      if (FIXED_PRIO || last_b_q) win_a = 1'b1;
      else                        win_b = 1'b1;
    end else begin
      win_a = bus.i_a_req;
      win_b = bus.i_b_req;
    end
  end

  assign gnt_a  = (state_q == IDLE) && win_a && !bus.i_flush && !rst;
  assign gnt_b  = (state_q == IDLE) && win_b && !bus.i_flush && !rst;
  assign accept = gnt_a || gnt_b;

  assign sel_dvd = gnt_b ? bus.i_b_dividend : bus.i_a_dividend;
  assign sel_dvs = gnt_b ? bus.i_b_divisor  : bus.i_a_divisor;
  assign sel_mod = gnt_b ? bus.i_b_is_mod   : bus.i_a_is_mod;

  // Partial remainder grows one bit, so the trial compare needs WIDTH+1 bits
  assign shift_r = {rem_q, quo_q[WIDTH-1]};
  assign step_ge = shift_r >= {1'b0, dvs_q};
  assign diff    = shift_r[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    is_mod_d = is_mod_q;
    id_d     = id_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_b_d = gnt_b;
          id_d     = gnt_b;
          is_mod_d = sel_mod;
          dvs_d    = sel_dvs;
          rem_d    = '0;
          cnt_d    = '0;
          if (sel_dvs == '0) begin
            quo_d   = '0;
            state_d = DONE;
          end else begin
            quo_d   = sel_dvd;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_ge ? diff : shift_r[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], step_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_mod_q <= 1'b0;
      id_q     <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_mod_q <= is_mod_d;
      id_q     <= id_d;
      last_b_q <= last_b_d;
    end
  end

  assign bus.o_a_gnt      = gnt_a;
  assign bus.o_b_gnt      = gnt_b;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_rsp_valid  = (state_q == DONE);
  assign bus.o_rsp_id     = id_q;
  assign bus.o_rsp_result = (state_q == DONE) ? (is_mod_q ? rem_q : quo_q) : '0;
endmodule
`default_nettype wire
